// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam logic [WAIT_W-1:0] TIMEOUT_MAX = 8'd255;
    localparam logic [BE_W-1:0]   BE_ALL      = 4'hF;

    // Command presented on the mem_* outputs for the granted transaction
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection: a lone request wins; on contention the requester
// that was not granted last wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
    input  owner_e last_own,
    output owner_e owner
);

    always_comb begin
        owner = OWN_LS;
        if (if_req && ls_req) begin
            owner = (last_own == OWN_IF) ? OWN_LS : OWN_IF;
        end else if (if_req) begin
            owner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Arbiter sharing one memory port between fetch and load/store requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is ls priority.
module mem_arb
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [BE_W-1:0]   ls_be,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic [DATA_W-1:0] rdata,
    output logic              if_done,
    output logic              ls_done,
    output logic              busy,
    output logic              err
);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    mem_cmd_t            cmd_q, cmd_d;
    logic                mem_en_q, mem_en_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                if_done_q, if_done_d;
    logic                ls_done_q, ls_done_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    owner_e              last_own_c;
    owner_e              pick_own_c;

`ifdef MEM_ARB_RR_EN
    owner_e              last_q, last_d;

    // Last-owner pointer; reset value makes fetch the next contended winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWN_LS;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && (if_req || ls_req)) begin
            last_d = pick_own_c;
        end
    end

    assign last_own_c = last_q;
`else
    // A permanent "fetch went last" makes the picker favour ls on contention
    assign last_own_c = OWN_IF;
`endif

    mem_arb_pick u_pick (
        .if_req   (if_req),
        .ls_req   (ls_req),
        .last_own (last_own_c),
        .owner    (pick_own_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            cmd_q     <= '0;
            mem_en_q  <= 1'b0;
            rdata_q   <= '0;
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cmd_q     <= cmd_d;
            mem_en_q  <= mem_en_d;
            rdata_q   <= rdata_d;
            if_done_q <= if_done_d;
            ls_done_q <= ls_done_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cmd_d     = cmd_q;
        mem_en_d  = mem_en_q;
        rdata_d   = rdata_q;
        if_done_d = 1'b0;
        ls_done_d = 1'b0;
        err_d     = err_q;
        wait_d    = wait_q;

        case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    state_d  = ACCESS;
                    owner_d  = pick_own_c;
                    mem_en_d = 1'b1;
                    wait_d   = '0;
                    if (pick_own_c == OWN_LS) begin
                        cmd_d.we    = ls_we;
                        cmd_d.addr  = ls_addr;
                        cmd_d.wdata = ls_wdata;
                        cmd_d.be    = ls_we ? ls_be : BE_ALL;
                    end else begin
                        cmd_d.we    = 1'b0;
                        cmd_d.addr  = if_addr;
                        cmd_d.wdata = '0;
                        cmd_d.be    = BE_ALL;
                    end
                end
            end

            ACCESS: begin
                if (mem_rdy) begin
                    state_d   = RESP;
                    mem_en_d  = 1'b0;
                    if_done_d = (owner_q == OWN_IF);
                    ls_done_d = (owner_q == OWN_LS);
                    if (!cmd_q.we) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    // The 255th stalled cycle aborts the access with zero data
                    if (wait_d == TIMEOUT_MAX) begin
                        state_d   = RESP;
                        mem_en_d  = 1'b0;
                        err_d     = 1'b1;
                        rdata_d   = '0;
                        if_done_d = (owner_q == OWN_IF);
                        ls_done_d = (owner_q == OWN_LS);
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_be    = cmd_q.be;
    assign rdata     = rdata_q;
    assign if_done   = if_done_q;
    assign ls_done   = ls_done_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [3:0]  ls_be = '0;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_rdy = 1'b0;
    logic [31:0] rdata;
    logic        if_done;
    logic        ls_done;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Reference model state: who won the last grant, last read data, sticky error
    bit          m_last_ls = 1'b1;
    logic [31:0] m_rdata = '0;
    bit          m_err = 1'b0;

    mem_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_be     (ls_be),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .rdata     (rdata),
        .if_done   (if_done),
        .ls_done   (ls_done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Winner rule: a lone requester wins; on contention ls wins, or with
    // round-robin the requester that did not win last time.
    function automatic bit model_pick_ls(input bit i_req, input bit l_req, input bit last_ls);
        if (i_req && l_req) begin
`ifdef MEM_ARB_RR_EN
            return !last_ls;
`else
            return 1'b1;
`endif
        end
        return l_req;
    endfunction

    // One complete transaction starting from IDLE with requests already driven.
    // The done pulse is visible in the cycle after the data edge, so it is
    // sampled by the second edge after the granting edge.
    task automatic run_txn(input int waits, input bit timeout, input logic [31:0] rd);
        bit          own_ls;
        bit          exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        int          n;
        own_ls    = model_pick_ls(if_req, ls_req, m_last_ls);
        m_last_ls = own_ls;
        exp_we    = own_ls && ls_we;
        exp_addr  = own_ls ? ls_addr : if_addr;
        exp_be    = exp_we ? ls_be : 4'hF;

        step();
        check("grant_en", 32'(mem_en), 32'd1);
        check("grant_busy", 32'(busy), 32'd1);
        check("grant_addr", mem_addr, exp_addr);
        check("grant_we", 32'(mem_we), 32'(exp_we));
        check("grant_be", 32'(mem_be), 32'(exp_be));
        if (exp_we) check("grant_wdata", mem_wdata, ls_wdata);
        check("grant_nodone", 32'({if_done, ls_done}), 32'd0);

        n = timeout ? 254 : waits;
        for (int i = 0; i < n; i++) begin
            mem_rdy = 1'b0;
            step();
            check("wait_en", 32'(mem_en), 32'd1);
            check("wait_nodone", 32'({if_done, ls_done}), 32'd0);
        end

        mem_rdy   = !timeout;
        mem_rdata = rd;
        step();
        if (timeout) begin
            m_rdata = 32'h0;
            m_err   = 1'b1;
        end else if (!exp_we) begin
            m_rdata = rd;
        end
        check("resp_en", 32'(mem_en), 32'd0);
        check("resp_if_done", 32'(if_done), 32'(!own_ls));
        check("resp_ls_done", 32'(ls_done), 32'(own_ls));
        check("resp_rdata", rdata, m_rdata);
        check("resp_err", 32'(err), 32'(m_err));
        check("resp_busy", 32'(busy), 32'd1);

        if (own_ls) ls_req = 1'b0;
        else        if_req = 1'b0;
        mem_rdy   = 1'b0;
        mem_rdata = $urandom;
        step();
        check("idle_done", 32'({if_done, ls_done}), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_err", 32'(err), 32'(m_err));
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_en", 32'(mem_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fetch alone
        if_req = 1'b1; if_addr = 32'h100;
        run_txn(0, 1'b0, 32'h00A00093);

        // Store
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200;
        ls_wdata = 32'hDEADBEEF; ls_be = 4'b0011;
        run_txn(0, 1'b0, 32'h12345678);

        // Load
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300; ls_be = 4'b0101;
        run_txn(0, 1'b0, 32'hCAFEF00D);

        // Three back-to-back contended grants, then drain
        for (int k = 0; k < 3; k++) begin
            if_req = 1'b1; if_addr = 32'h400 + 32'(k);
            ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500 + 32'(k);
            run_txn(0, 1'b0, $urandom);
        end
        for (int k = 0; k < 2; k++) begin
            if (if_req || ls_req) run_txn(0, 1'b0, $urandom);
        end

        // Five wait states
        if_req = 1'b1; if_addr = 32'h600;
        run_txn(5, 1'b0, 32'h0BADC0DE);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (!ls_req && $urandom_range(0, 1) == 1) begin
                ls_req = 1'b1; ls_we = 1'($urandom); ls_addr = $urandom;
                ls_wdata = $urandom; ls_be = 4'($urandom);
            end
            if (!if_req && !ls_req) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            run_txn($urandom_range(0, 3), 1'b0, $urandom);
        end
        for (int k = 0; k < 2; k++) begin
            if (if_req || ls_req) run_txn(0, 1'b0, $urandom);
        end

        // Timeout, then the following request is still served
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h700;
        run_txn(0, 1'b1, 32'hFFFFFFFF);
        if_req = 1'b1; if_addr = 32'h800;
        run_txn(1, 1'b0, 32'h13579BDF);

        // Reset in the middle of an access
        if_req = 1'b1; if_addr = 32'h900;
        step();
        mem_rdy = 1'b0;
        step();
        check("pre_rst_en", 32'(mem_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_en", 32'(mem_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_be", 32'(mem_be), 32'd0);
        m_last_ls = 1'b1;
        m_rdata   = '0;
        m_err     = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_no_done", 32'({if_done, ls_done}), 32'd0);
        end
        rst_n = 1'b1;
        run_txn(0, 1'b0, 32'h2468ACE0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The module SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch word address
- ls_req  in  1  load/store request, level, held until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  32  load/store address
- ls_wdata  in  32  store data
- ls_be  in  4  store byte enables
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables; 4'hF on reads
- mem_rdata  in  32  memory read data, valid with mem_rdy
- mem_rdy  in  1  memory completes the access this cycle
- rdata  out  32  captured read data, valid while a done pulse is high
- if_done  out  1  one-cycle completion pulse for fetch
- ls_done  out  1  one-cycle completion pulse for load/store
- busy  out  1  1 when state is not IDLE
- err  out  1  sticky timeout flag

Function
REQ-003 The state machine SHALL have three states: IDLE, ACCESS and RESP.
REQ-004 In IDLE, when any request is high at a clock edge, the module SHALL grant one requester, register its address, data, byte enables and write flag onto the mem_* outputs, and go to ACCESS.
REQ-005 In ACCESS, mem_en SHALL be 1; on the edge where mem_rdy=1, the module SHALL capture mem_rdata into rdata (loads and fetches only), clear mem_en and go to RESP.
REQ-006 In RESP, the done pulse of the granted owner SHALL be 1 for exactly one cycle, and the state SHALL return to IDLE.
REQ-007 Requesters SHALL drop req at the edge that samples done unless they issue a new request; a req that is high in IDLE counts as a new transaction.
REQ-008 With mem_rdy tied to 1, latency from the edge that samples req to done high SHALL be 2 cycles, and throughput SHALL be one transaction every 3 cycles.
REQ-009 If both requests are high in IDLE and MEM_ARB_RR_EN is undefined, ls SHALL win.
REQ-010 Request changes during ACCESS or RESP SHALL be ignored; the owner SHALL not change mid-transaction.
REQ-011 An ACCESS wait counter (8 bits) SHALL count cycles with mem_rdy=0; at 255 it SHALL set err, force RESP with rdata=32'h0, and pulse the owner's done.
REQ-012 err SHALL stay set until reset.
REQ-013 mem_we SHALL be 0 for fetches, and mem_be SHALL be 4'hF for fetches and loads.

Reset
REQ-014 Asserting rst_n low, including mid-transaction, SHALL immediately force IDLE and clear mem_en, mem_we, if_done, ls_done, busy and err; mem_addr, mem_wdata, rdata and the wait counter SHALL go to 0, mem_be to 4'h0, and the round-robin pointer to "IF next".

Configuration
REQ-015 When MEM_ARB_RR_EN is defined, simultaneous requests SHALL be granted round-robin: a 1-bit last-owner register gives priority to the requester not granted last, and it updates at each grant.
REQ-016 When MEM_ARB_RR_EN is undefined, arbitration SHALL be fixed ls-priority and the pointer register SHALL not exist.

Structure
REQ-017 Package mem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), the owner encoding (OWN_IF=0, OWN_LS=1) and the constant TIMEOUT_MAX=8'd255.
REQ-018 Grant selection SHALL be in one combinational sub-module, mem_arb_pick (inputs: if_req, ls_req, last-owner pointer; output: owner).

Verification
REQ-019 The bench SHALL cover these scenarios:
- Fetch alone: if_req=1, if_addr=32'h100, mem_rdy=1, mem_rdata=32'h00A00093 -> mem_en one cycle with mem_addr=32'h100; if_done one cycle, 2 cycles after the req edge, with rdata=32'h00A00093.
- Store: ls_we=1, ls_addr=32'h200, ls_wdata=32'hDEADBEEF, ls_be=4'b0011 -> mem_we=1, mem_be=4'b0011, mem_wdata=32'hDEADBEEF; ls_done pulses; if_done stays 0.
- Contention: both req high in IDLE -> without the macro, ls first then if; with MEM_ARB_RR_EN, grants alternate if, ls, if across 3 back-to-back contended cycles.
- Wait states: mem_rdy low for 5 cycles -> mem_en held 6 cycles; done exactly once; err=0.
- Timeout: mem_rdy held 0 -> err=1 after 255 wait cycles, done pulses, rdata=0, next request still served.
- Reset mid-ACCESS: rst_n low -> mem_en=0 and busy=0 immediately, no done pulse; after release, a new request completes normally.
